// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus between the fetch stage and imem.
//   f_imem_req_o    - fetch request valid (driven by fetch)
//   f_imem_addr_o   - 4-byte aligned fetch address (driven by fetch)
//   f_imem_gnt_i    - request accepted when req & gnt (driven by memory)
//   f_imem_rvalid_i - in-order response valid (driven by memory)
//   f_imem_rdata_i  - response instruction word (driven by memory)
interface fetch_unit_if;
   logic        f_imem_req_o;
   logic [63:0] f_imem_addr_o;
   logic        f_imem_gnt_i;
   logic        f_imem_rvalid_i;
   logic [31:0] f_imem_rdata_i;
   modport master (output f_imem_req_o, f_imem_addr_o, input f_imem_gnt_i, f_imem_rvalid_i, f_imem_rdata_i);
   modport slave (input f_imem_req_o, f_imem_addr_o, output f_imem_gnt_i, f_imem_rvalid_i, f_imem_rdata_i);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RV64I fetch stage - owns the PC, issues imem fetches, buffers words, feeds decode.
//   clk, rst        - clock and asynchronous active-high reset
//   imem            - instruction-memory bus (fetch_unit_if.master)
//   f_valid_o/f_ready_i, f_instr_o, f_pc_o - instruction handoff to decode
//   f_branch_i/f_jump_jal_i/f_jump_jalr_i with f_pc_b_i/f_pc_jal_i/f_pc_jalr_i - redirects from decode
//   f_misalign_o    - one-cycle pulse after a redirect to a target with [1:0] != 0
module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master imem,
   output logic         f_valid_o,
   input  logic         f_ready_i,
   output logic [31:0]  f_instr_o,
   output logic [63:0]  f_pc_o,
   input  logic         f_branch_i,
   input  logic         f_jump_jal_i,
   input  logic         f_jump_jalr_i,
   input  logic [63:0]  f_pc_b_i,
   input  logic [63:0]  f_pc_jal_i,
   input  logic [63:0]  f_pc_jalr_i,
   output logic         f_misalign_o
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [CW:0] LIM = DEPTH[CW:0];
   typedef logic [CW-1:0] cnt_t;
   typedef logic [PW-1:0] ptr_t;

   logic [63:0] pc_q, pc_d;
   cnt_t        out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d, cnt_q, cnt_d;
   ptr_t        rd_q, rd_d, wr_q, wr_d, prd_q, prd_d, pwr_q, pwr_d;
   logic        misalign_q, misalign_d;
   logic [31:0] instr_q [DEPTH];
   logic [63:0] ipc_q [DEPTH];
   logic [63:0] ppc_q [DEPTH];
   logic        pop, redir, req, gnt, rv, drop, push;
   logic [63:0] tgt;
   logic [CW:0] occ;

   function automatic ptr_t inc(ptr_t p);
      return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign f_valid_o          = cnt_q != '0;
   assign f_instr_o          = instr_q[rd_q];
   assign f_pc_o             = ipc_q[rd_q];
   assign f_misalign_o       = misalign_q;
   assign imem.f_imem_req_o  = req;
   assign imem.f_imem_addr_o = pc_q;

   always_comb begin
      pop        = f_valid_o & f_ready_i;
      redir      = pop & (f_branch_i | f_jump_jal_i | f_jump_jalr_i);
      tgt        = f_jump_jalr_i ? f_pc_jalr_i : f_jump_jal_i ? f_pc_jal_i : f_pc_b_i;
      // credit: in-flight plus buffered words may never exceed the buffer, counting this cycle's pop
      occ        = {1'b0, out_cnt_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};
      req        = !rst & !redir & (occ < LIM);
      gnt        = req & imem.f_imem_gnt_i;
      rv         = imem.f_imem_rvalid_i;
      drop       = rv & (drop_cnt_q != '0);
      push       = rv & !drop & !redir;
      pc_d       = redir ? {tgt[63:2], 2'b00} : gnt ? pc_q + 64'd4 : pc_q;
      out_cnt_d  = out_cnt_q + cnt_t'(gnt) - cnt_t'(rv);
      // on redirect every still-outstanding response becomes wrong-path
      drop_cnt_d = redir ? drop_cnt_q + out_cnt_q + cnt_t'(gnt) - cnt_t'(rv) : drop_cnt_q - cnt_t'(drop);
      cnt_d      = redir ? '0 : cnt_q + cnt_t'(push) - cnt_t'(pop);
      rd_d       = redir ? wr_q : pop ? inc(rd_q) : rd_q;
      wr_d       = push ? inc(wr_q) : wr_q;
      pwr_d      = gnt ? inc(pwr_q) : pwr_q;
      prd_d      = rv ? inc(prd_q) : prd_q;
      misalign_d = redir & (tgt[1:0] != 2'b00);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         out_cnt_q  <= '0;
         drop_cnt_q <= '0;
         cnt_q      <= '0;
         rd_q       <= '0;
         wr_q       <= '0;
         prd_q      <= '0;
         pwr_q      <= '0;
         misalign_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            ipc_q[i]   <= '0;
            ppc_q[i]   <= '0;
         end
      end else begin
         pc_q       <= pc_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         prd_q      <= prd_d;
         pwr_q      <= pwr_d;
         misalign_q <= misalign_d;
         if (gnt) ppc_q[pwr_q] <= pc_q;
         if (push) begin
            instr_q[wr_q] <= imem.f_imem_rdata_i;
            ipc_q[wr_q]   <= ppc_q[prd_q];
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with an in-order imem model.
module tb_fetch_unit;
   localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        f_valid_o, f_ready_i, f_misalign_o;
   logic        f_branch_i, f_jump_jal_i, f_jump_jalr_i;
   logic [31:0] f_instr_o;
   logic [63:0] f_pc_o, f_pc_b_i, f_pc_jal_i, f_pc_jalr_i;
   logic [63:0] exp_pc;
   int          errors = 0, checks = 0, cyc = 0, lat = 1;
   typedef struct { logic [63:0] addr; int due; } rsp_t;
   rsp_t pend[$];

   fetch_unit_if imem();

   fetch_unit dut (
      .clk(clk), .rst(rst), .imem(imem),
      .f_valid_o(f_valid_o), .f_ready_i(f_ready_i), .f_instr_o(f_instr_o), .f_pc_o(f_pc_o),
      .f_branch_i(f_branch_i), .f_jump_jal_i(f_jump_jal_i), .f_jump_jalr_i(f_jump_jalr_i),
      .f_pc_b_i(f_pc_b_i), .f_pc_jal_i(f_pc_jal_i), .f_pc_jalr_i(f_pc_jalr_i),
      .f_misalign_o(f_misalign_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] word(logic [63:0] a);
      return a[31:0] ^ 32'h1357_9BDF;
   endfunction

   always @(negedge clk) begin
      if (rst) pend.delete();
      else if (imem.f_imem_req_o && imem.f_imem_gnt_i) pend.push_back('{imem.f_imem_addr_o, cyc + lat});
   end

   always @(negedge clk) begin
      if (!rst && (int'(dut.out_cnt_q) + int'(dut.cnt_q) > 2)) begin
         errors++;
         $display("FAIL credit: out_cnt+cnt=%0d required <= 2", int'(dut.out_cnt_q) + int'(dut.cnt_q));
      end
   end

   initial begin
      imem.f_imem_rvalid_i = 1'b0;
      imem.f_imem_rdata_i  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem.f_imem_rvalid_i = 1'b1;
            imem.f_imem_rdata_i  = word(pend[0].addr);
            void'(pend.pop_front());
         end else begin
            imem.f_imem_rvalid_i = 1'b0;
            imem.f_imem_rdata_i  = 32'hDEAD_BEEF;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      f_ready_i = 1'b1;
      imem.f_imem_gnt_i = 1'b1;
      {f_branch_i, f_jump_jal_i, f_jump_jalr_i} = 3'b000;
      f_pc_b_i = '0;
      f_pc_jal_i = '0;
      f_pc_jalr_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (imem.f_imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem.f_imem_req_o); end
      checks++;
      if (f_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", f_valid_o); end
      checks++;
      if (f_misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", f_misalign_o); end
      checks++;
      if (imem.f_imem_addr_o !== RPC) begin errors++; $display("FAIL reset_addr: got %h want %h", imem.f_imem_addr_o, RPC); end
      checks++;
      if (f_instr_o !== 32'h0 || f_pc_o !== 64'h0) begin errors++; $display("FAIL reset_out: got instr=%h pc=%h want 0 0", f_instr_o, f_pc_o); end
   endtask

   task automatic test_start;
      lat = 1;
      tick;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if (imem.f_imem_req_o !== 1'b1 || imem.f_imem_addr_o !== RPC + 64'(4 * k)) begin
            errors++;
            $display("FAIL start_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", k, imem.f_imem_req_o, imem.f_imem_addr_o, RPC + 64'(4 * k));
         end
         checks++;
         if (f_valid_o !== (k >= 2)) begin errors++; $display("FAIL start_valid[%0d]: got %b want %b", k, f_valid_o, k >= 2); end
         if (k >= 2) begin
            checks++;
            if (f_pc_o !== RPC + 64'(4 * (k - 2)) || f_instr_o !== word(RPC + 64'(4 * (k - 2)))) begin
               errors++;
               $display("FAIL start_pc[%0d]: got pc=%h instr=%h want pc=%h", k, f_pc_o, f_instr_o, RPC + 64'(4 * (k - 2)));
            end
         end
         tick;
      end
      exp_pc = RPC + 64'd16;
   endtask

   task automatic test_backpressure;
      logic [63:0] base;
      base = exp_pc;
      f_ready_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (imem.f_imem_req_o !== 1'b0) begin errors++; $display("FAIL bp_req[%0d]: got %b want 0", k, imem.f_imem_req_o); end
         checks++;
         if (f_valid_o !== 1'b1 || f_pc_o !== base || f_instr_o !== word(base)) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got valid=%b pc=%h instr=%h want 1 %h", k, f_valid_o, f_pc_o, f_instr_o, base);
         end
         tick;
      end
      f_ready_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) begin
            checks++;
            if (imem.f_imem_req_o !== 1'b1 || imem.f_imem_addr_o !== base + 64'd8) begin
               errors++;
               $display("FAIL bp_resume: got req=%b addr=%h want 1 %h", imem.f_imem_req_o, imem.f_imem_addr_o, base + 64'd8);
            end
         end
         if (f_valid_o && f_ready_i) begin
            checks++;
            if (f_pc_o !== exp_pc || f_instr_o !== word(exp_pc)) begin
               errors++;
               $display("FAIL bp_seq: got pc=%h instr=%h want pc=%h", f_pc_o, f_instr_o, exp_pc);
            end
            exp_pc += 64'd4;
         end
         tick;
      end
      checks++;
      if (exp_pc !== base + 64'd24) begin errors++; $display("FAIL bp_count: consumed up to %h want %h", exp_pc, base + 64'd24); end
   endtask

   task automatic test_grant_stall;
      logic [63:0] base;
      base = exp_pc;
      imem.f_imem_gnt_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) imem.f_imem_gnt_i = 1'b1;
         @(negedge clk);
         checks++;
         if (imem.f_imem_req_o !== 1'b1 || imem.f_imem_addr_o !== base + 64'd8) begin
            errors++;
            $display("FAIL stall_addr[%0d]: got req=%b addr=%h want 1 %h", k, imem.f_imem_req_o, imem.f_imem_addr_o, base + 64'd8);
         end
         if (f_valid_o && f_ready_i) begin
            checks++;
            if (f_pc_o !== exp_pc || f_instr_o !== word(exp_pc)) begin
               errors++;
               $display("FAIL stall_seq: got pc=%h instr=%h want pc=%h", f_pc_o, f_instr_o, exp_pc);
            end
            exp_pc += 64'd4;
         end
         tick;
      end
      @(negedge clk);
      checks++;
      if (imem.f_imem_addr_o !== base + 64'd12) begin errors++; $display("FAIL stall_advance: got addr=%h want %h", imem.f_imem_addr_o, base + 64'd12); end
      tick;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (f_valid_o && f_ready_i) begin
            checks++;
            if (f_pc_o !== exp_pc || f_instr_o !== word(exp_pc)) begin
               errors++;
               $display("FAIL stall_seq: got pc=%h instr=%h want pc=%h", f_pc_o, f_instr_o, exp_pc);
            end
            exp_pc += 64'd4;
         end
         tick;
      end
   endtask

   task automatic test_branch_flush;
      int n;
      lat = 3;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (f_valid_o && f_ready_i) begin
            checks++;
            if (f_pc_o !== exp_pc || f_instr_o !== word(exp_pc)) begin
               errors++;
               $display("FAIL br_seq: got pc=%h instr=%h want pc=%h", f_pc_o, f_instr_o, exp_pc);
            end
            exp_pc += 64'd4;
         end
         tick;
      end
      n = 0;
      while (!f_valid_o && n < 20) begin tick; n++; end
      checks++;
      if (!f_valid_o) begin errors++; $display("FAIL br_wait: got valid=0 want 1 within 20 cycles"); end
      f_branch_i = 1'b1;
      f_pc_b_i = 64'h0000_0000_8000_0100;
      @(negedge clk);
      checks++;
      if (imem.f_imem_req_o !== 1'b0 || f_pc_o !== exp_pc) begin
         errors++;
         $display("FAIL br_take: got req=%b pc=%h want req=0 pc=%h", imem.f_imem_req_o, f_pc_o, exp_pc);
      end
      tick;
      f_branch_i = 1'b0;
      @(negedge clk);
      checks++;
      if (imem.f_imem_req_o !== 1'b1 || imem.f_imem_addr_o !== 64'h0000_0000_8000_0100 || f_valid_o !== 1'b0 || f_misalign_o !== 1'b0) begin
         errors++;
         $display("FAIL br_target: got req=%b addr=%h valid=%b mis=%b want 1 80000100 0 0", imem.f_imem_req_o, imem.f_imem_addr_o, f_valid_o, f_misalign_o);
      end
      tick;
      n = 2;
      while (!f_valid_o && n < 12) begin tick; n++; end
      checks++;
      if (n !== 5 || f_pc_o !== 64'h0000_0000_8000_0100 || f_instr_o !== word(64'h0000_0000_8000_0100)) begin
         errors++;
         $display("FAIL br_first: got delay=%0d pc=%h instr=%h want delay=5 pc=80000100", n, f_pc_o, f_instr_o);
      end
      exp_pc = 64'h0000_0000_8000_0100;
   endtask

   task automatic test_priority_misalign;
      logic [2:0]  sel [2];
      logic [63:0] tj [2], tl [2], tb [2], ea [2];
      logic        em [2];
      int n;
      sel[0] = 3'b101; tj[0] = 64'h8000_0202; tl[0] = 64'h8000_0300; tb[0] = 64'h8000_0400; ea[0] = 64'h8000_0200; em[0] = 1'b1;
      sel[1] = 3'b011; tj[1] = 64'h8000_0502; tl[1] = 64'h8000_0300; tb[1] = 64'h8000_0401; ea[1] = 64'h8000_0300; em[1] = 1'b0;
      lat = 1;
      for (int v = 0; v < 2; v++) begin
         n = 0;
         while (!f_valid_o && n < 20) begin tick; n++; end
         {f_jump_jalr_i, f_jump_jal_i, f_branch_i} = sel[v];
         f_pc_jalr_i = tj[v];
         f_pc_jal_i = tl[v];
         f_pc_b_i = tb[v];
         @(negedge clk);
         checks++;
         if (f_valid_o !== 1'b1 || imem.f_imem_req_o !== 1'b0 || f_pc_o !== exp_pc) begin
            errors++;
            $display("FAIL pri_take[%0d]: got valid=%b req=%b pc=%h want 1 0 %h", v, f_valid_o, imem.f_imem_req_o, f_pc_o, exp_pc);
         end
         tick;
         {f_jump_jalr_i, f_jump_jal_i, f_branch_i} = 3'b000;
         @(negedge clk);
         checks++;
         if (imem.f_imem_req_o !== 1'b1 || imem.f_imem_addr_o !== ea[v]) begin
            errors++;
            $display("FAIL pri_addr[%0d]: got req=%b addr=%h want 1 %h", v, imem.f_imem_req_o, imem.f_imem_addr_o, ea[v]);
         end
         checks++;
         if (f_misalign_o !== em[v]) begin errors++; $display("FAIL pri_mis[%0d]: got %b want %b", v, f_misalign_o, em[v]); end
         tick;
         @(negedge clk);
         checks++;
         if (f_misalign_o !== 1'b0) begin errors++; $display("FAIL pri_mis_pulse[%0d]: got %b want 0", v, f_misalign_o); end
         tick;
         checks++;
         if (f_valid_o !== 1'b1 || f_pc_o !== ea[v] || f_instr_o !== word(ea[v])) begin
            errors++;
            $display("FAIL pri_first[%0d]: got valid=%b pc=%h instr=%h want 1 %h", v, f_valid_o, f_pc_o, f_instr_o, ea[v]);
         end
         exp_pc = ea[v];
      end
   endtask

   task automatic test_reset_mid;
      f_ready_i = 1'b0;
      repeat (4) tick;
      @(negedge clk);
      checks++;
      if (f_valid_o !== 1'b1 || dut.cnt_q !== 2'd2 || imem.f_imem_req_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_full: got valid=%b cnt=%0d req=%b want 1 2 0", f_valid_o, dut.cnt_q, imem.f_imem_req_o);
      end
      tick;
      rst = 1'b1;
      #1;
      checks++;
      if (f_valid_o !== 1'b0 || imem.f_imem_req_o !== 1'b0 || imem.f_imem_addr_o !== RPC) begin
         errors++;
         $display("FAIL mid_reset: got valid=%b req=%b addr=%h want 0 0 %h", f_valid_o, imem.f_imem_req_o, imem.f_imem_addr_o, RPC);
      end
      f_ready_i = 1'b1;
      tick;
      tick;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (imem.f_imem_req_o !== 1'b1 || imem.f_imem_addr_o !== RPC) begin
         errors++;
         $display("FAIL mid_restart: got req=%b addr=%h want 1 %h", imem.f_imem_req_o, imem.f_imem_addr_o, RPC);
      end
      tick;
      tick;
      checks++;
      if (f_valid_o !== 1'b1 || f_pc_o !== RPC || f_instr_o !== word(RPC)) begin
         errors++;
         $display("FAIL mid_first: got valid=%b pc=%h instr=%h want 1 %h", f_valid_o, f_pc_o, f_instr_o, RPC);
      end
   endtask

   initial begin
      test_reset;
      test_start;
      test_backpressure;
      test_grant_stall;
      test_branch_flush;
      test_priority_misalign;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
